// File: rtl/power_sequencer.sv
// power_sequencer: staged rail sequencer (ramp, settle, reverse shutdown, latched fault).
// Define SEQ_AUTO_RETRY_EN to enable timed auto-restart after a fault.

module power_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_TIMEOUT  = 1000,
    parameter int SETTLE_DELAY   = 100,
    parameter int SHUTDOWN_DELAY = 50,
    parameter int RETRY_DELAY    = 3000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_clearFault,
    input  logic [NUM_STAGES-1:0] i_stageGood,
    output logic [NUM_STAGES-1:0] o_stageEnable,
    output logic                  o_allGood,
    output logic                  o_fault,
    output logic [1:0]            o_faultStage,
    output logic [2:0]            o_state
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

`ifdef SEQ_AUTO_RETRY_EN
    localparam int MAX_DELAY = max_of(max_of(STAGE_TIMEOUT, SETTLE_DELAY),
                                      max_of(SHUTDOWN_DELAY, RETRY_DELAY));
`else
    localparam int MAX_DELAY = max_of(max_of(STAGE_TIMEOUT, SETTLE_DELAY), SHUTDOWN_DELAY);
`endif
    localparam int TW = max_of($clog2(MAX_DELAY + 1), 1);

    typedef logic [TW-1:0]         timer_t;
    typedef logic [NUM_STAGES-1:0] stages_t;

    localparam timer_t TIMER_SAT     = timer_t'(MAX_DELAY);
    localparam timer_t RAMP_LAST     = timer_t'(STAGE_TIMEOUT - 1);
    localparam timer_t SETTLE_LAST   = timer_t'(SETTLE_DELAY - 1);
    localparam timer_t SHUTDOWN_LAST = timer_t'(SHUTDOWN_DELAY - 1);
    localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

`ifdef SEQ_AUTO_RETRY_EN
    localparam int RW = max_of($clog2(MAX_RETRIES + 1), 1);
    typedef logic [RW-1:0] retry_t;
    localparam timer_t RETRY_LAST  = timer_t'(RETRY_DELAY - 1);
    localparam retry_t RETRY_LIMIT = retry_t'(MAX_RETRIES);
`endif

    if (NUM_STAGES < 2 || NUM_STAGES > 4 || STAGE_TIMEOUT < 1 || SETTLE_DELAY < 1 ||
        SHUTDOWN_DELAY < 1 || RETRY_DELAY < 1 || MAX_RETRIES < 0) begin : g_bad_params
        $error("power_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RAMP       = 3'd1,
        S_SETTLE     = 3'd2,
        S_ON         = 3'd3,
        S_SHUTDOWN   = 3'd4,
        S_FAULT      = 3'd5,
        S_RETRY_WAIT = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] k_q, k_d;
    timer_t     timer_q, timer_d;
    stages_t    en_q, en_d;
    logic       allgood_q;
    logic       fault_q;
    logic [1:0] fstage_q, fstage_d;
`ifdef SEQ_AUTO_RETRY_EN
    retry_t     retry_q, retry_d;
`endif

    stages_t    cur;
    logic       cur_good;
    stages_t    fault_mask;
    logic [1:0] fault_idx;
    timer_t     timer_inc;
    state_t     fault_target;

    always_comb begin
        cur       = stages_t'(1) << k_q;
        cur_good  = |(i_stageGood & cur);
        timer_inc = (timer_q == TIMER_SAT) ? timer_q : timer_q + timer_t'(1);

        // Guard on every enabled stage; the ramping stage only counts once its timeout expires.
        fault_mask = '0;
        if (state_q == S_RAMP || state_q == S_SETTLE || state_q == S_ON) begin
            fault_mask = en_q & ~i_stageGood;
            if (state_q == S_RAMP) begin
                fault_mask = fault_mask & ~cur;
                if (!cur_good && timer_q == RAMP_LAST) begin
                    fault_mask = fault_mask | cur;
                end
            end
        end

        fault_idx = '0;
        for (int unsigned j = NUM_STAGES; j > 0; j--) begin
            if (fault_mask[j-1]) begin
                fault_idx = 2'(j - 1);
            end
        end

`ifdef SEQ_AUTO_RETRY_EN
        fault_target = (retry_q == RETRY_LIMIT) ? S_FAULT : S_RETRY_WAIT;
`else
        fault_target = S_FAULT;
`endif
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        timer_d  = timer_q;
        en_d     = en_q;
        fstage_d = fstage_q;
`ifdef SEQ_AUTO_RETRY_EN
        retry_d  = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
                en_d    = '0;
                k_d     = '0;
                timer_d = '0;
                if (i_enable) begin
                    state_d = S_RAMP;
                    en_d    = stages_t'(1);
                end
            end

            S_RAMP, S_SETTLE, S_ON: begin
                if (|fault_mask) begin
                    state_d  = fault_target;
                    en_d     = '0;
                    timer_d  = '0;
                    fstage_d = fault_idx;
                end else if (!i_enable) begin
                    // Enabled stages always form a contiguous run from bit 0,
                    // so dropping the highest one is a right shift.
                    en_d    = en_q >> 1;
                    timer_d = '0;
                    state_d = ((en_q >> 1) == '0) ? S_IDLE : S_SHUTDOWN;
                end else begin
                    case (state_q)
                        S_RAMP: begin
                            if (cur_good) begin
                                state_d = S_SETTLE;
                                timer_d = '0;
                            end else begin
                                timer_d = timer_inc;
                            end
                        end
                        S_SETTLE: begin
                            if (timer_q == SETTLE_LAST) begin
                                timer_d = '0;
                                if (k_q == LAST_STAGE) begin
                                    state_d = S_ON;
`ifdef SEQ_AUTO_RETRY_EN
                                    retry_d = '0;
`endif
                                end else begin
                                    state_d = S_RAMP;
                                    k_d     = k_q + 2'd1;
                                    en_d    = en_q | (cur << 1);
                                end
                            end else begin
                                timer_d = timer_inc;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_SHUTDOWN: begin
                if (timer_q == SHUTDOWN_LAST) begin
                    en_d    = en_q >> 1;
                    timer_d = '0;
                    if ((en_q >> 1) == '0) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end

            S_FAULT: begin
                en_d = '0;
                if (i_clearFault) begin
                    state_d  = S_IDLE;
                    fstage_d = '0;
                    timer_d  = '0;
                end
            end

`ifdef SEQ_AUTO_RETRY_EN
            S_RETRY_WAIT: begin
                en_d = '0;
                if (i_clearFault) begin
                    state_d  = S_IDLE;
                    fstage_d = '0;
                    timer_d  = '0;
                    retry_d  = '0;
                end else if (timer_q == RETRY_LAST) begin
                    state_d  = S_IDLE;
                    fstage_d = '0;
                    timer_d  = '0;
                    retry_d  = retry_q + retry_t'(1);
                end else begin
                    timer_d = timer_inc;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                en_d    = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            timer_q   <= '0;
            en_q      <= '0;
            allgood_q <= 1'b0;
            fault_q   <= 1'b0;
            fstage_q  <= '0;
`ifdef SEQ_AUTO_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            en_q      <= en_d;
            allgood_q <= (state_d == S_ON);
            fault_q   <= (state_d == S_FAULT) || (state_d == S_RETRY_WAIT);
            fstage_q  <= fstage_d;
`ifdef SEQ_AUTO_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign o_stageEnable = en_q;
    assign o_allGood     = allgood_q;
    assign o_fault       = fault_q;
    assign o_faultStage  = fstage_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// tb_power_sequencer: directed plus randomized stimulus against a stage-count reference model.
// Exercises SEQ_AUTO_RETRY_EN behaviour when that macro is defined for the build.

module tb_power_sequencer;

    localparam int NS  = 3;
    localparam int TO  = 8;
    localparam int STL = 4;
    localparam int SHD = 2;
    localparam int RD  = 5;
    localparam int MR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic [NS-1:0] good;
    logic [NS-1:0] stage_en;
    logic          all_good;
    logic          fault;
    logic [1:0]    fault_stage;
    logic [2:0]    state;

    power_sequencer #(
        .NUM_STAGES     (NS),
        .STAGE_TIMEOUT  (TO),
        .SETTLE_DELAY   (STL),
        .SHUTDOWN_DELAY (SHD),
        .RETRY_DELAY    (RD),
        .MAX_RETRIES    (MR)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_clearFault  (clr),
        .i_stageGood   (good),
        .o_stageEnable (stage_en),
        .o_allGood     (all_good),
        .o_fault       (fault),
        .o_faultStage  (fault_stage),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: number of enabled stages plus cycles spent in the current phase.
    int m_mode = 0;
    int m_n = 0;
    int m_cnt = 0;
    int m_fstage = 0;
    int m_retries = 0;

    // Rail plant: each stage reports good dly cycles after its enable, unless killed.
    int            age [NS];
    int            dly [NS];
    int            dly_cfg [NS];
    logic [NS-1:0] kill;
    bit            rand_dly;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic bound(input string tag, input bit ok);
        if (!ok) begin
            errors++;
            $error("FAIL %s: cycle budget expired", tag);
        end
    endtask

    task automatic model_step();
        int bad;
        if (rst) begin
            m_mode = 0; m_n = 0; m_cnt = 0; m_fstage = 0; m_retries = 0;
            return;
        end
        case (m_mode)
            0: if (en) begin m_mode = 1; m_n = 1; m_cnt = 0; end
            1, 2, 3: begin
                bad = -1;
                for (int j = NS - 1; j >= 0; j--) begin
                    if (j < m_n) begin
                        if (m_mode == 1 && j == m_n - 1) begin
                            if (!good[j] && m_cnt + 1 == TO) bad = j;
                        end else if (!good[j]) begin
                            bad = j;
                        end
                    end
                end
                if (bad >= 0) begin
                    m_n = 0; m_cnt = 0; m_fstage = bad;
`ifdef SEQ_AUTO_RETRY_EN
                    m_mode = (m_retries == MR) ? 5 : 6;
`else
                    m_mode = 5;
`endif
                end else if (!en) begin
                    m_n--; m_cnt = 0;
                    m_mode = (m_n == 0) ? 0 : 4;
                end else if (m_mode == 1) begin
                    if (good[m_n-1]) begin m_mode = 2; m_cnt = 0; end
                    else m_cnt++;
                end else if (m_mode == 2) begin
                    m_cnt++;
                    if (m_cnt == STL) begin
                        m_cnt = 0;
                        if (m_n == NS) begin m_mode = 3; m_retries = 0; end
                        else begin m_n++; m_mode = 1; end
                    end
                end
            end
            4: begin
                m_cnt++;
                if (m_cnt == SHD) begin
                    m_cnt = 0; m_n--;
                    if (m_n == 0) m_mode = 0;
                end
            end
            5: if (clr) begin m_mode = 0; m_fstage = 0; end
            6: begin
                if (clr) begin
                    m_mode = 0; m_retries = 0; m_fstage = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == RD) begin m_mode = 0; m_retries++; m_fstage = 0; m_cnt = 0; end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic plant_update();
        for (int j = 0; j < NS; j++) begin
            if (j < m_n) begin
                if (age[j] == 0) dly[j] = rand_dly ? int'($urandom_range(0, 10)) : dly_cfg[j];
                if (age[j] < 100000) age[j]++;
            end else begin
                age[j] = 0;
            end
        end
    endtask

    task automatic tick();
        for (int j = 0; j < NS; j++) good[j] = (age[j] >= dly[j]) && !kill[j];
        @(posedge clk);
        model_step();
        plant_update();
        #1;
        chk("state", 8'(state), 8'(m_mode));
        chk("stage_enable", 8'(stage_en), 8'((1 << m_n) - 1));
        chk("all_good", 8'(all_good), 8'(m_mode == 3));
        chk("fault", 8'(fault), 8'(m_mode == 5 || m_mode == 6));
        chk("fault_stage", 8'(fault_stage), 8'(m_fstage));
    endtask

    initial begin
        int rw_entries;
        logic [2:0] prev_state;
        rst = 1'b1; en = 1'b0; clr = 1'b0; kill = '0; rand_dly = 1'b0;
        for (int j = 0; j < NS; j++) begin age[j] = 0; dly[j] = 2; dly_cfg[j] = 2; end

        repeat (3) tick();
        chk("reset_state", 8'(state), 8'd0);
        chk("reset_enable", 8'(stage_en), 8'd0);
        chk("reset_fault", 8'(fault), 8'd0);
        rst = 1'b0;
        tick();

        // Nominal power-up: ON after 3*(2+4) cycles from the first enable.
        en = 1'b1;
        repeat (18) tick();
        chk("nominal_allgood_early", 8'(all_good), 8'd0);
        tick();
        chk("nominal_allgood", 8'(all_good), 8'd1);
        chk("nominal_enables", 8'(stage_en), 8'h07);

        // Reverse shutdown.
        en = 1'b0;
        tick();
        chk("shutdown_first", 8'(stage_en), 8'h03);
        chk("shutdown_allgood", 8'(all_good), 8'd0);
        repeat (2) tick();
        chk("shutdown_second", 8'(stage_en), 8'h01);
        repeat (2) tick();
        chk("shutdown_done", 8'(stage_en), 8'h00);
        chk("shutdown_idle", 8'(state), 8'd0);

        // Ramp timeout on stage 1, then clear with enable still high.
        dly_cfg[1] = 1000;
        en = 1'b1;
        for (int i = 0; i < 50 && m_n != 2; i++) tick();
        bound("timeout_reach_stage1", m_n == 2);
        repeat (7) tick();
        chk("timeout_not_yet", 8'(fault), 8'd0);
        tick();
        chk("timeout_fault", 8'(fault), 8'd1);
        chk("timeout_stage", 8'(fault_stage), 8'd1);
        chk("timeout_enables", 8'(stage_en), 8'd0);
        dly_cfg[1] = 2;
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clear_idle", 8'(state), 8'd0);
        tick();
        chk("rerampp_enable", 8'(stage_en), 8'h01);

        // Fault in ON on two stages at once: lowest index reported.
        for (int i = 0; i < 50 && m_mode != 3; i++) tick();
        bound("reach_on_1", m_mode == 3);
        kill[0] = 1'b1; kill[2] = 1'b1;
        tick();
        chk("on_fault_stage", 8'(fault_stage), 8'd0);
        chk("on_fault_state", 8'(state), 8'd5);
        kill = '0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 50 && m_mode != 3; i++) tick();
        bound("reach_on_2", m_mode == 3);
        kill[1] = 1'b1; en = 1'b0;
        tick();
        chk("fault_beats_disable", 8'(state), 8'd5);
        chk("fault_beats_disable_stage", 8'(fault_stage), 8'd1);
        kill = '0;
        clr = 1'b1; tick(); clr = 1'b0;
        tick();

        // Mid-ramp reset.
        en = 1'b1;
        for (int i = 0; i < 50 && m_n != 2; i++) tick();
        bound("reset_reach_stage1", m_n == 2);
        rst = 1'b1; tick();
        chk("midramp_reset_enable", 8'(stage_en), 8'd0);
        chk("midramp_reset_state", 8'(state), 8'd0);
        rst = 1'b0; en = 1'b0;
        tick();

`ifdef SEQ_AUTO_RETRY_EN
        // Stage 0 never good: MR retries, then the next timeout latches FAULT.
        dly_cfg[0] = 1000;
        en = 1'b1;
        rw_entries = 0;
        prev_state = state;
        for (int i = 0; i < 300 && m_mode != 5; i++) begin
            tick();
            if (state == 3'd6 && prev_state != 3'd6) rw_entries++;
            prev_state = state;
        end
        bound("retry_reach_fault", m_mode == 5);
        chk("retry_count", 8'(rw_entries), 8'(MR));
        chk("retry_fault_state", 8'(state), 8'd5);
        chk("retry_fault_stage", 8'(fault_stage), 8'd0);
        dly_cfg[0] = 2; en = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
`else
        rw_entries = 0;
        prev_state = '0;
`endif

        // Randomized soak.
        rand_dly = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) en = ~en;
            clr = ($urandom_range(9) == 0);
            rst = ($urandom_range(499) == 0);
            if ($urandom_range(149) == 0) kill[$urandom_range(NS - 1)] = 1'b1;
            if ($urandom_range(29) == 0 || m_mode == 5) kill = '0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
